// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, frame shape
// and the bit-timing helpers that turn clock and baud rates into cycle counts.
// No ports; imported by uart_rx, uart_sync's users, uart_rx_if and uart_tx.
package uart_pkg;

  // Receiver/transmitter frame state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // 8N1 framing.
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // System clocks per line bit (integer division, truncates).
  function automatic int calc_clks_per_bit(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

  // Offset from the start edge to the middle of the start bit.
  function automatic int calc_half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bundle: the serial line, the byte hand-off and status pulses.
// master: drives serial_rx and rx_ready, observes the received byte and status.
// slave : the receiver; consumes serial_rx/rx_ready, drives data and status.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 serial_rx;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data_out;
  logic                 rx_valid;
  logic                 rx_frame_err;
  logic                 rx_overrun;
  logic                 rx_busy;

  modport master (
    output serial_rx,
    output rx_ready,
    input  rx_data_out,
    input  rx_valid,
    input  rx_frame_err,
    input  rx_overrun,
    input  rx_busy
  );

  modport slave (
    input  serial_rx,
    input  rx_ready,
    output rx_data_out,
    output rx_valid,
    output rx_frame_err,
    output rx_overrun,
    output rx_busy
  );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer bringing the asynchronous serial line into clk domain.
// Ports: clk, rst_n (async active-low), d (async in), q (synchronized out).
// Both flops reset to 1 so a line held idle-high sees no edge at reset release.
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-byte holding register and valid/ready hand-off.
// Ports: clk, rst_n (async active-low), serial_rx line in, rx_ready/rx_valid/
// rx_data_out byte hand-off, rx_frame_err/rx_overrun pulses, rx_busy status.
// Latency: byte appears 3 + HALF_BIT + 9*CLKS_PER_BIT clocks after the start
// edge; a byte completing while the previous one is still held is dropped.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE       = 9600
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serial_rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int HALF_BIT     = calc_half_bit(CLKS_PER_BIT);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  // Terminal counts: the counter runs 0..N-1, so N clocks elapse per period.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  uart_state_t          state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [2:0]           idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_sync;
  logic                 shift_en;
  logic                 stop_smp;
  logic                 consume;

  uart_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (serial_rx),
    .q     (rx_sync)
  );

  // ---------------------------------------------------------------------------
  // Frame FSM: state and bit-timing registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic. shift_en marks a data-bit sample, stop_smp the stop-bit
  // sample; the datapath below acts on those strobes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_en  = 1'b0;
    stop_smp  = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (!rx_sync) begin
          state_nxt = ST_START;
        end
      end

      ST_START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          // A line already back high mid-start-bit was a glitch.
          state_nxt = rx_sync ? ST_IDLE : ST_DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt  = '0;
          shift_en = 1'b1;
          if (idx == IDX_LAST) begin
            idx_nxt   = '0;
            state_nxt = ST_STOP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt  = '0;
          stop_smp = 1'b1;
          // Straight back to IDLE: the sample sits mid stop bit, so the next
          // start edge can be caught without an extra idle bit.
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  assign rx_busy = (state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Datapath: LSB-first shift register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (shift_en) begin
      shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Holding register and status pulses.
  // A consume on the same edge as a good stop sample frees the register, so
  // the new byte is loaded and rx_valid never drops.
  // ---------------------------------------------------------------------------
  assign consume = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_out  <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;

      if (stop_smp && rx_sync) begin
        if (!rx_valid || rx_ready) begin
          rx_data_out <= shreg;
          rx_valid    <= 1'b1;
        end else begin
          // Held byte still pending: keep it, drop the new one.
          rx_overrun <= 1'b1;
        end
      end else begin
        if (stop_smp) begin
          rx_frame_err <= 1'b1;
        end
        if (consume) begin
          rx_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a scaled bit rate (16 clocks per bit).
// Ports: none; drives the receiver through a uart_rx_if instance.
// Frames are generated bit-accurately here; expected values are hand-derived.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_HZ   = 1600;
  localparam int BAUD     = 100;
  localparam int CPB      = 16;                  // 1600/100
  localparam int HALF     = 8;                   // 16/2
  localparam int STOP_LAT = 3 + HALF + 9 * CPB;  // start edge -> stop sample = 155

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  uart_rx_if bus ();

  uart_rx #(
    .CLOCK_FREQUENCY (CLK_HZ),
    .BAUD_RATE       (BAUD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .serial_rx    (bus.serial_rx),
    .rx_ready     (bus.rx_ready),
    .rx_data_out  (bus.rx_data_out),
    .rx_valid     (bus.rx_valid),
    .rx_frame_err (bus.rx_frame_err),
    .rx_overrun   (bus.rx_overrun),
    .rx_busy      (bus.rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Output event monitor, sampled on the falling edge.
  int   vld_rise = 0, vld_fall = 0, vld_rise_cyc = 0;
  int   ferr_hi = 0, ovr_hi = 0, ovr_cyc = 0;
  logic vld_q = 1'b0;
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1 && vld_q !== 1'b1) begin
      vld_rise     = vld_rise + 1;
      vld_rise_cyc = cyc;
    end
    if (bus.rx_valid === 1'b0 && vld_q === 1'b1) vld_fall = vld_fall + 1;
    vld_q = bus.rx_valid;
    if (bus.rx_frame_err === 1'b1) ferr_hi = ferr_hi + 1;
    if (bus.rx_overrun === 1'b1) begin
      ovr_hi  = ovr_hi + 1;
      ovr_cyc = cyc;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int start_cyc = 0;

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    bus.serial_rx = v;
    wait_clks(CPB);
  endtask

  // One 8N1 frame; optionally pulses rx_ready exactly on the stop-sample edge
  // (the 11th edge of the stop bit, see STOP_LAT).
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit rdy_at_stop);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    bus.serial_rx = stop_v;
    if (rdy_at_stop) begin
      wait_clks(10);
      bus.rx_ready = 1'b1;
      wait_clks(1);
      bus.rx_ready = 1'b0;
      wait_clks(5);
    end else begin
      wait_clks(CPB);
    end
  endtask

  task automatic consume_byte();
    bus.rx_ready = 1'b1;
    wait_clks(1);
    bus.rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    wait_clks(3);
    n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid); end
    n_checks++; if (bus.rx_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.rx_data_out); end
    n_checks++; if (bus.rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", bus.rx_frame_err); end
    n_checks++; if (bus.rx_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", bus.rx_overrun); end
    n_checks++; if (bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.rx_busy); end
    rst_n = 1'b1;
    wait_clks(4);
    n_checks++; if (bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", bus.rx_busy); end
  endtask

  task automatic test_loopback();
    int r0 = vld_rise, f0 = ferr_hi, o0 = ovr_hi;
    send_frame(8'hA5, 1'b1, 1'b0);
    n_checks++; if (vld_rise != r0 + 1) begin n_fail++; $display("FAIL lb_valid_rise: got %0d want %0d", vld_rise - r0, 1); end
    n_checks++; if (vld_rise_cyc - start_cyc != STOP_LAT) begin n_fail++; $display("FAIL lb_latency: got %0d want %0d", vld_rise_cyc - start_cyc, STOP_LAT); end
    n_checks++; if (bus.rx_data_out !== 8'hA5) begin n_fail++; $display("FAIL lb_data: got %h want a5", bus.rx_data_out); end
    n_checks++; if (ferr_hi != f0 || ovr_hi != o0) begin n_fail++; $display("FAIL lb_no_err: got ferr %0d ovr %0d want 0 0", ferr_hi - f0, ovr_hi - o0); end
    consume_byte();
    n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL lb_consume: got %b want 0", bus.rx_valid); end
    n_checks++; if (bus.rx_data_out !== 8'hA5) begin n_fail++; $display("FAIL lb_data_hold: got %h want a5", bus.rx_data_out); end
  endtask

  task automatic test_false_start();
    int r0 = vld_rise, f0 = ferr_hi;
    bus.serial_rx = 1'b0;
    wait_clks(3);
    bus.serial_rx = 1'b1;
    wait_clks(5);
    n_checks++; if (bus.rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy: got %b want 1", bus.rx_busy); end
    wait_clks(6);
    n_checks++; if (bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got %b want 0", bus.rx_busy); end
    n_checks++; if (vld_rise != r0 || ferr_hi != f0) begin n_fail++; $display("FAIL glitch_quiet: got vld %0d ferr %0d want 0 0", vld_rise - r0, ferr_hi - f0); end
    wait_clks(CPB);
    send_frame(8'h3C, 1'b1, 1'b0);
    n_checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data_out !== 8'h3C) begin n_fail++; $display("FAIL glitch_next: got %b/%h want 1/3c", bus.rx_valid, bus.rx_data_out); end
    consume_byte();
  endtask

  task automatic test_frame_err();
    int r0 = vld_rise, f0 = ferr_hi;
    send_frame(8'h55, 1'b0, 1'b0);
    bus.serial_rx = 1'b1;
    n_checks++; if (ferr_hi != f0 + 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d cycles want 1", ferr_hi - f0); end
    n_checks++; if (bus.rx_valid !== 1'b0 || vld_rise != r0) begin n_fail++; $display("FAIL ferr_valid: got %b want 0", bus.rx_valid); end
    n_checks++; if (bus.rx_data_out !== 8'h3C) begin n_fail++; $display("FAIL ferr_noload: got %h want 3c", bus.rx_data_out); end
    wait_clks(40);
    n_checks++; if (bus.rx_busy !== 1'b0 || ferr_hi != f0 + 1) begin n_fail++; $display("FAIL ferr_recover: got busy %b ferr %0d want 0 1", bus.rx_busy, ferr_hi - f0); end
  endtask

  task automatic test_back_to_back();
    int o0 = ovr_hi, f0 = ferr_hi;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    n_checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data_out !== 8'h00) begin n_fail++; $display("FAIL b2b_keep: got %b/%h want 1/00", bus.rx_valid, bus.rx_data_out); end
    n_checks++; if (ovr_hi != o0 + 1) begin n_fail++; $display("FAIL b2b_ovr_pulse: got %0d cycles want 1", ovr_hi - o0); end
    n_checks++; if (ovr_cyc - start_cyc != STOP_LAT) begin n_fail++; $display("FAIL b2b_ovr_time: got %0d want %0d", ovr_cyc - start_cyc, STOP_LAT); end
    n_checks++; if (ferr_hi != f0) begin n_fail++; $display("FAIL b2b_ferr: got %0d want 0", ferr_hi - f0); end
    consume_byte();
    n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_consume: got %b want 0", bus.rx_valid); end
  endtask

  task automatic test_ready_at_complete();
    int fl0, o0;
    send_frame(8'h11, 1'b1, 1'b0);
    fl0 = vld_fall;
    o0  = ovr_hi;
    send_frame(8'h22, 1'b1, 1'b1);
    n_checks++; if (bus.rx_data_out !== 8'h22) begin n_fail++; $display("FAIL rac_data: got %h want 22", bus.rx_data_out); end
    n_checks++; if (bus.rx_valid !== 1'b1 || vld_fall != fl0) begin n_fail++; $display("FAIL rac_valid: got %b falls %0d want 1 0", bus.rx_valid, vld_fall - fl0); end
    n_checks++; if (ovr_hi != o0) begin n_fail++; $display("FAIL rac_ovr: got %0d want 0", ovr_hi - o0); end
  endtask

  // Byte 0x22 is still held when reset hits during bit 4 of 0x81.
  task automatic test_reset_mid();
    logic [7:0] b;
    int f0;
    b = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    bus.serial_rx = b[4];
    wait_clks(8);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", bus.rx_busy); end
    n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", bus.rx_valid); end
    n_checks++; if (bus.rx_data_out !== 8'h00) begin n_fail++; $display("FAIL rmid_data: got %h want 00", bus.rx_data_out); end
    bus.serial_rx = 1'b1;
    wait_clks(2);
    rst_n = 1'b1;
    f0 = ferr_hi;
    wait_clks(20);
    n_checks++; if (bus.rx_busy !== 1'b0 || bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: got busy %b valid %b want 0 0", bus.rx_busy, bus.rx_valid); end
    send_frame(8'h7E, 1'b1, 1'b0);
    n_checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data_out !== 8'h7E) begin n_fail++; $display("FAIL rmid_next: got %b/%h want 1/7e", bus.rx_valid, bus.rx_data_out); end
    n_checks++; if (ferr_hi != f0) begin n_fail++; $display("FAIL rmid_ferr: got %0d want 0", ferr_hi - f0); end
  endtask

  initial begin
    bus.serial_rx = 1'b1;
    bus.rx_ready  = 1'b0;
    test_reset();
    test_loopback();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_ready_at_complete();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50000000, system clock in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line bit rate in bits/s.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port serial_rx  input  1  asynchronous UART line, idle high, 8N1 framing.
REQ-006 SHALL have port rx_ready  input  1  consumer accepts the held byte when high with rx_valid.
REQ-007 SHALL have port rx_data_out  output  8  last received byte.
REQ-008 SHALL have port rx_valid  output  1  rx_data_out holds an unconsumed byte.
REQ-009 SHALL have port rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port rx_overrun  output  1  one-cycle pulse: completed byte dropped because rx_valid was still pending.
REQ-011 SHALL have port rx_busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 SHALL derive CLKS_PER_BIT = CLOCK_FREQUENCY/BAUD_RATE (integer division; 5208 at defaults) and HALF_BIT = CLKS_PER_BIT/2.
REQ-013 SHALL pass serial_rx through a 2-flop synchronizer; all decisions use the synchronized value only.
REQ-014 SHALL implement states IDLE, START, DATA, STOP.
REQ-015 IDLE -> START on synchronized line low; bit-period counter cleared.
REQ-016 START: after HALF_BIT clocks, sample line; low -> DATA, high -> IDLE (false start, no outputs asserted).
REQ-017 DATA: sample once every CLKS_PER_BIT clocks; shift in 8 bits, LSB first; after bit 7 -> STOP.
REQ-018 STOP: after CLKS_PER_BIT clocks, sample line and return to IDLE in the same cycle (allows back-to-back frames, no extra idle bit needed).
REQ-019 Stop sample high and rx_valid low (or rx_valid && rx_ready that cycle): load rx_data_out, rx_valid high on the next clock.
REQ-020 Stop sample high while rx_valid high and rx_ready low: keep old rx_data_out, pulse rx_overrun one cycle, drop new byte.
REQ-021 Stop sample low: pulse rx_frame_err one cycle; no load, rx_valid unchanged.
REQ-022 rx_valid SHALL stay high until a clock edge with rx_ready high, then clear, unless REQ-019 reloads it that same edge.
REQ-023 rx_data_out SHALL be stable while rx_valid is high.
REQ-024 rx_ready while rx_valid low SHALL have no effect.
REQ-025 Bit-period counter width SHALL be clog2(CLKS_PER_BIT) bits; bit index 3 bits; no wrap beyond terminal count.

Reset
REQ-026 On rst_n low, asynchronously: state IDLE, counters 0, synchronizer flops 1, rx_data_out 0x00, rx_valid 0, rx_frame_err 0, rx_overrun 0, rx_busy 0.
REQ-027 Reset mid-frame SHALL discard the partial byte; after release, the block waits for a fresh high-to-low start edge.

Structure
REQ-028 State encoding, CLKS_PER_BIT/HALF_BIT calculation and frame constants (8 data bits, 1 stop bit) SHALL live in shared package uart_pkg, also used by uart_tx.
REQ-029 The 2-flop synchronizer SHALL be sub-module uart_sync (reset value 1); all other logic in uart_rx.

Verification
REQ-030 Loopback from uart_tx (defaults) sending 0xA5 -> rx_valid high about 9.5x5208 clocks after start edge, rx_data_out=0xA5, no error pulses.
REQ-031 Low glitch of 1000 clocks on idle line -> no rx_valid/rx_frame_err, rx_busy drops after HALF_BIT, next frame 0x3C received correctly.
REQ-032 Frame 0x55 with stop bit forced low -> single-cycle rx_frame_err, rx_valid stays 0.
REQ-033 Back-to-back 0x00 then 0xFF, rx_ready held low -> rx_data_out=0x00, rx_overrun single pulse at second stop sample; rx_ready pulse then clears rx_valid.
REQ-034 rst_n low during DATA bit 4 of 0x81 -> all outputs at reset values immediately; subsequent 0x7E received correctly.
REQ-035 rx_ready high on the exact cycle the next byte completes -> old byte consumed, new byte loaded, rx_valid stays high, no rx_overrun.
